// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants for the synchronizer filter bank
package sync_pkg;

  localparam int                      GLITCH_CNT_W    = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX  = 8'd255;
  localparam int                      MIN_SYNC_STAGES = 2;
  localparam int                      MIN_FILTER_LEN  = 1;

endpackage

// File: rtl/sync_filter_chan.sv
// rtl/sync_filter_chan.sv - one channel: sync chain, deglitch filter, edge pulses
//
// Optional feature macro: SYNC_GLITCH_COUNT_EN (adds glitch_clr/glitch_cnt).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   async_in     asynchronous level input
//   filt_bypass  1 = data_out follows the synchronized input without filtering
//   glitch_clr   clears the glitch counter (macro only)
//   glitch_cnt   saturating count of aborted transitions (macro only)
//   data_out     synchronized, filtered level
//   rise_pulse   one-cycle pulse on data_out 0->1
//   fall_pulse   one-cycle pulse on data_out 1->0
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 3,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    async_in,
  input  logic                    filt_bypass,
`ifdef SYNC_GLITCH_COUNT_EN
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic                    data_out,
  output logic                    rise_pulse,
  output logic                    fall_pulse
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("sync_filter_chan: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < MIN_FILTER_LEN) begin : g_bad_filter_len
    $error("sync_filter_chan: FILTER_LEN must be >= 1");
  end

  // A one-cycle filter still needs a one-bit counter to keep widths legal.
  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_data;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_sq;
  logic                   w_next_data;
  logic [CNT_W-1:0]       w_next_cnt;

  assign w_sq = r_sync[SYNC_STAGES-1];

  // A new level is accepted only once it has been seen for FILTER_LEN
  // consecutive cycles; any return to the current level restarts the count.
  always_comb begin
    w_next_data = r_data;
    w_next_cnt  = '0;
    if (filt_bypass) begin
      w_next_data = w_sq;
    end else if (w_sq != r_data) begin
      if (r_cnt == CNT_LAST) begin
        w_next_data = w_sq;
      end else begin
        w_next_cnt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      r_cnt  <= '0;
      r_data <= RESET_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_cnt  <= w_next_cnt;
      r_data <= w_next_data;
      r_rise <= w_next_data & ~r_data;
      r_fall <= ~w_next_data & r_data;
    end
  end

  assign data_out   = r_data;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef SYNC_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] r_gcnt;
  logic                    w_glitch;

  // A pending change that falls back to the held level before acceptance.
  assign w_glitch = ~filt_bypass && (r_cnt != '0) && (w_sq == r_data);

  always_ff @(posedge clk) begin
    if (rst || glitch_clr) begin
      r_gcnt <= '0;
    end else if (w_glitch && (r_gcnt != GLITCH_CNT_MAX)) begin
      r_gcnt <= r_gcnt + GLITCH_CNT_W'(1);
    end
  end

  assign glitch_cnt = r_gcnt;
`endif

endmodule

// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - multi-channel synchronizer and deglitch filter bank
//
// Optional feature macro: SYNC_GLITCH_COUNT_EN (adds glitch_clr/glitch_cnt).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   async_in     asynchronous inputs, one bit per channel
//   filt_bypass  per-channel filter bypass
//   glitch_clr   clears all glitch counters (macro only)
//   glitch_cnt   8-bit counter per channel, channel i in [8i+7:8i] (macro only)
//   data_out     synchronized, filtered levels
//   rise_pulse   per-channel one-cycle rising-edge pulses
//   fall_pulse   per-channel one-cycle falling-edge pulses
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   SYNC_STAGES = 3,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS-1:0]              async_in,
  input  logic [CHANNELS-1:0]              filt_bypass,
`ifdef SYNC_GLITCH_COUNT_EN
  input  logic                             glitch_clr,
  output logic [CHANNELS*GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic [CHANNELS-1:0]              data_out,
  output logic [CHANNELS-1:0]              rise_pulse,
  output logic [CHANNELS-1:0]              fall_pulse
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_filter_bank: CHANNELS must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .async_in    (async_in[i]),
      .filt_bypass (filt_bypass[i]),
`ifdef SYNC_GLITCH_COUNT_EN
      .glitch_clr  (glitch_clr),
      .glitch_cnt  (glitch_cnt[i*GLITCH_CNT_W +: GLITCH_CNT_W]),
`endif
      .data_out    (data_out[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i])
    );
  end

endmodule

// File: doc/sync_filter_bank.md
# sync_filter_bank

Multi-channel input conditioner that brings asynchronous level signals (1PPS, T2-MI status, lock and alarm lines) into the `clk` domain. Each channel has a parametrised synchronizer chain, a stability (deglitch) filter and registered rise/fall pulse outputs. It generalises the fixed two-stage synchronizer to N channels with configurable depth, filtering, per-channel bypass and optional glitch statistics. It sits at the board-input boundary, ahead of the PPS timing and T2-MI monitoring logic.

## Interface
- `CHANNELS`, 4: number of independent input channels; must be ≥1.
- `SYNC_STAGES`, 3: synchronizer flops per channel; must be ≥2.
- `FILTER_LEN`, 4: consecutive cycles a new level must persist before `data_out` follows; must be ≥1.
- `RESET_LEVEL`, 1'b0: reset value of every sync flop and every `data_out` bit.
- `clk  in  1  system clock`
- `rst  in  1  reset: synchronous, active-high`
- `async_in  in  CHANNELS  asynchronous inputs, one bit per channel`
- `filt_bypass  in  CHANNELS  synchronous; 1 = skip the filter for that channel`
- `data_out  out  CHANNELS  synchronized, filtered level`
- `rise_pulse  out  CHANNELS  one-cycle pulse on a 0→1 change of `data_out``
- `fall_pulse  out  CHANNELS  one-cycle pulse on a 1→0 change of `data_out``
- `glitch_clr  in  1  clears all glitch counters (only with SYNC_GLITCH_COUNT_EN)`
- `glitch_cnt  out  CHANNELS*8  per-channel glitch counters, channel i in bits [8i+7:8i] (only with SYNC_GLITCH_COUNT_EN)`

## Operation
- Parameter violations (`CHANNELS<1`, `SYNC_STAGES<2`, `FILTER_LEN<1`) cause an elaboration error.
- Sync chain: a shift register of `SYNC_STAGES` flops per channel. Its last stage is `sq`. There is no logic between stages.
- Filter, per channel, with counter `cnt` of width $clog2(FILTER_LEN):
  - Bypass = 1: `data_out <= sq` and `cnt <= 0`.
  - `sq == data_out`: `cnt <= 0`.
  - `sq != data_out` and `cnt == FILTER_LEN-1`: `data_out <= sq` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- Pulses are registered on the same edge as the `data_out` update. `rise_pulse[i]` = new `data_out[i]` & ~old `data_out[i]`. `fall_pulse[i]` is the converse. Pulses are never wider than one cycle.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Bypass toggled while `cnt≠0`: the counter is discarded. `data_out` takes `sq` on the next edge, with a pulse if the level changes. This is not counted as a glitch.
- Reset (`rst=1` at a clock edge):
  - Sync flops and `data_out` go to `RESET_LEVEL`.
  - `cnt`, pulses and glitch counters go to 0.
  - Any in-progress filtering is discarded and no pulse is generated.
  - Reset has priority over every other action.
- After reset release, an input held at ~`RESET_LEVEL` is treated as a normal transition. It is filtered and produces one pulse.

## Timing
- The input is first sampled at edge 0.
- `sq` reflects it after edge `SYNC_STAGES-1`.
- Filtered path: `data_out` and its pulse update at edge `SYNC_STAGES+FILTER_LEN-1`. With defaults this is edge 6, i.e. the 7th sampling edge.
- Bypass path: update at edge `SYNC_STAGES`.
- The shortest input pulse that passes the filter is `FILTER_LEN` cycles of `sq`. Shorter pulses are suppressed completely.
- Throughput is one decision per channel per cycle. There are no handshakes and no stalls.

## Configuration
- `SYNC_GLITCH_COUNT_EN` defined: adds `glitch_clr`, `glitch_cnt` and per-channel 8-bit saturating counters.
- A glitch is counted when, with bypass = 0, `cnt≠0` and `sq == data_out`, i.e. a change aborted before acceptance.
- Counters saturate at 255.
- `glitch_clr` zeroes all counters on the next edge. If clear and a glitch coincide, clear wins and the result is 0.
- Not defined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `sync_pkg` holds:
  - `GLITCH_CNT_W = 8`
  - `GLITCH_CNT_MAX = 8'd255`
  - `MIN_SYNC_STAGES = 2`
  - `MIN_FILTER_LEN = 1`
- Sub-module `sync_filter_chan`: one channel, containing the chain, filter, pulses and optional counter. It is instantiated `CHANNELS` times in a generate loop. The top level only concatenates the buses.

## Test plan
All scenarios use default parameters.
- Reset hold: `rst=1` for 2 cycles with `async_in=4'hF` → `data_out=0`, all pulses 0, `glitch_cnt=0`. After release, with `async_in[0]` held at 1 → `data_out[0]=1` and `rise_pulse[0]` for one cycle at the 7th edge after release.
- Clean step: `async_in[1]` 0→1, held, first sampled at edge 0 → `data_out[1]` rises at edge 6, `rise_pulse[1]` is high only in that cycle. Dropping back to 0 → `fall_pulse[1]` fires 6 edges later.
- Glitch: `async_in[2]` high for 3 cycles → `data_out[2]` stays 0, no pulse, `glitch_cnt[2]=1` (macro on). A 4-cycle pulse passes as a 4-cycle `data_out` pulse.
- Bypass: `filt_bypass[3]=1` with a 1-cycle input pulse → `data_out[3]` high for exactly 1 cycle at edge 3, `rise_pulse` then `fall_pulse` on consecutive cycles.
- Saturation/clear: 300 glitches on channel 0 → `glitch_cnt[0]=255`. `glitch_clr` in the same cycle as a glitch → 0.
- Reset mid-filter: `cnt=2` on channel 1 when `rst` pulses for 1 cycle → `data_out` returns to `RESET_LEVEL`, no pulse, and the filter restarts from `cnt=0`.
